// File: rtl/crop_pad_embed.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// crop_pad_embed : places a cropped raster stream into a larger frame, padding
//                  every position outside the window with a constant pixel.
// Revision       : 1.0  initial release
// =============================================================================
module crop_pad_embed #(
   parameter int PIXEL_BIT_WIDTH = 12,
   parameter int IN_ROWS         = 20,
   parameter int IN_COLS         = 20,
   parameter int OUT_ROWS        = 40,
   parameter int OUT_COLS        = 40,
   parameter int Y_1             = 10,
   parameter int X_1             = 10,
   parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
   input  logic                       pixel_in_TVALID,
   output logic                       pixel_in_TREADY,
   output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
   output logic                       pixel_out_TVALID,
   input  logic                       pixel_out_TREADY,
   output logic                       pixel_out_TUSER,
   output logic                       pixel_out_TLAST,
   output logic                       busy
);

   localparam int c_XW = $clog2(OUT_COLS) + 1;
   localparam int c_YW = $clog2(OUT_ROWS) + 1;
   localparam logic [c_XW-1:0] c_X_LO   = c_XW'(X_1);
   localparam logic [c_XW-1:0] c_X_HI   = c_XW'(X_1 + IN_COLS);
   localparam logic [c_XW-1:0] c_X_LAST = c_XW'(OUT_COLS - 1);
   localparam logic [c_YW-1:0] c_Y_LO   = c_YW'(Y_1);
   localparam logic [c_YW-1:0] c_Y_HI   = c_YW'(Y_1 + IN_ROWS);
   localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(OUT_ROWS - 1);

   generate
      if ((Y_1 + IN_ROWS > OUT_ROWS) || (X_1 + IN_COLS > OUT_COLS)) begin : g_bad_geometry
         $error("crop_pad_embed: input window does not fit inside the output frame");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                     r_state;
   logic [c_XW-1:0]            r_x;
   logic [c_YW-1:0]            r_y;
   logic [PIXEL_BIT_WIDTH-1:0] r_data;
   logic                       r_valid;
   logic                       r_user;
   logic                       r_last;

   logic w_in_win;
   logic w_out_free;
   logic w_load;
   logic w_x_end;
   logic w_y_end;

   assign w_in_win   = (r_y >= c_Y_LO) && (r_y < c_Y_HI) && (r_x >= c_X_LO) && (r_x < c_X_HI);
   assign w_out_free = !r_valid || pixel_out_TREADY;
   assign w_x_end    = (r_x == c_X_LAST);
   assign w_y_end    = (r_y == c_Y_LAST);
   // Pad positions advance without waiting for input; window positions need a pixel.
   assign w_load     = (r_state == S_RUN) && w_out_free && (w_in_win ? pixel_in_TVALID : 1'b1);

   assign pixel_in_TREADY  = (r_state == S_RUN) && w_in_win && w_out_free;
   assign pixel_out_TDATA  = r_data;
   assign pixel_out_TVALID = r_valid;
   assign pixel_out_TUSER  = r_user;
   assign pixel_out_TLAST  = r_last;
   assign busy             = (r_state == S_RUN) || r_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_user  <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         if (w_load) begin
            r_data  <= w_in_win ? pixel_in_TDATA : PAD_VALUE;
            r_user  <= (r_x == '0) && (r_y == '0);
            r_last  <= w_x_end;
            r_valid <= 1'b1;
         end else if (pixel_out_TREADY) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (pixel_in_TVALID) begin
                  r_state <= S_RUN;
                  r_x     <= '0;
                  r_y     <= '0;
               end
            end
            S_RUN: begin
               if (w_load) begin
                  if (w_x_end) begin
                     r_x <= '0;
                     if (w_y_end) begin
                        r_y     <= '0;
                        r_state <= S_IDLE;
                     end else begin
                        r_y <= r_y + c_YW'(1);
                     end
                  end else begin
                     r_x <= r_x + c_XW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_crop_pad_embed.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_crop_pad_embed : vector table, hand-written corner sequences and random
//                     streams checked against a frame-level reference model.
// Revision          : 1.0  initial release
// =============================================================================
module tb_crop_pad_embed;

   localparam int W   = 12;
   localparam int PAD = 7;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic [W-1:0] in_data   = '0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic         sel       = 1'b0;

   logic         c_in_ready, c_valid, c_user, c_last, c_busy;
   logic [W-1:0] c_data;
   logic         e_in_ready, e_valid, e_user, e_last, e_busy;
   logic [W-1:0] e_data;

   logic         in_ready, o_valid, o_user, o_last, o_busy;
   logic [W-1:0] o_data;

   always #5 clk = ~clk;

   crop_pad_embed #(
      .PIXEL_BIT_WIDTH(W), .IN_ROWS(2), .IN_COLS(2), .OUT_ROWS(4), .OUT_COLS(4),
      .Y_1(1), .X_1(1), .PAD_VALUE(12'd7)
   ) u_dut (
      .clk(clk), .reset(reset),
      .pixel_in_TDATA(in_data), .pixel_in_TVALID(in_valid), .pixel_in_TREADY(c_in_ready),
      .pixel_out_TDATA(c_data), .pixel_out_TVALID(c_valid), .pixel_out_TREADY(out_ready),
      .pixel_out_TUSER(c_user), .pixel_out_TLAST(c_last), .busy(c_busy)
   );

   crop_pad_embed #(
      .PIXEL_BIT_WIDTH(W), .IN_ROWS(2), .IN_COLS(2), .OUT_ROWS(4), .OUT_COLS(4),
      .Y_1(2), .X_1(2), .PAD_VALUE(12'd7)
   ) u_dut_edge (
      .clk(clk), .reset(reset),
      .pixel_in_TDATA(in_data), .pixel_in_TVALID(in_valid), .pixel_in_TREADY(e_in_ready),
      .pixel_out_TDATA(e_data), .pixel_out_TVALID(e_valid), .pixel_out_TREADY(out_ready),
      .pixel_out_TUSER(e_user), .pixel_out_TLAST(e_last), .busy(e_busy)
   );

   assign in_ready = sel ? e_in_ready : c_in_ready;
   assign o_valid  = sel ? e_valid    : c_valid;
   assign o_data   = sel ? e_data     : c_data;
   assign o_user   = sel ? e_user     : c_user;
   assign o_last   = sel ? e_last     : c_last;
   assign o_busy   = sel ? e_busy     : c_busy;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] in_q [$];
   logic [W-1:0] od_q [$];
   bit           ou_q [$];
   bit           ol_q [$];
   int           oc_q [$];
   logic [W-1:0] ed_q [$];
   bit           eu_q [$];
   bit           el_q [$];
   int           idx;
   int           cyc;

   int g_rows, g_cols, g_ir, g_ic, g_y1, g_x1;

   typedef struct {
      int px [4];
      int vmode;
      int rmode;
      int exp [16];
   } vec_t;
   vec_t tbl [4];

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic select_dut(input bit s);
      sel    = s;
      g_rows = 4;
      g_cols = 4;
      g_ir   = 2;
      g_ic   = 2;
      g_y1   = s ? 2 : 1;
      g_x1   = s ? 2 : 1;
   endtask

   task automatic clear_run();
      in_q.delete(); od_q.delete(); ou_q.delete(); ol_q.delete(); oc_q.delete();
      ed_q.delete(); eu_q.delete(); el_q.delete();
      idx = 0;
      cyc = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One cycle: drive at the falling edge, then record the handshakes that the next rising edge commits.
   task automatic step(input bit v, input bit r);
      @(negedge clk);
      in_valid  = v && (idx < in_q.size());
      in_data   = (idx < in_q.size()) ? in_q[idx] : '0;
      out_ready = r;
      #1;
      cyc++;
      if (in_valid && in_ready) idx++;
      if (o_valid && out_ready) begin
         od_q.push_back(o_data);
         ou_q.push_back(o_user);
         ol_q.push_back(o_last);
         oc_q.push_back(cyc);
      end
   endtask

   task automatic run_stream(input int target, input int vmode, input int rmode);
      bit v, r;
      while (od_q.size() < target && cyc < 4000) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = ($urandom % 4) != 0;
         endcase
         r = (rmode == 0) ? 1'b1 : (($urandom % 3) != 0);
         step(v, r);
      end
      if (od_q.size() < target) begin
         checks++;
         failures++;
         $display("FAIL stream_timeout actual=%0d outputs required=%0d", od_q.size(), target);
      end
   endtask

   // Reference: each output position is either the matching input pixel or padding.
   task automatic model_frame(input int base);
      bit win;
      for (int y = 0; y < g_rows; y++) begin
         for (int x = 0; x < g_cols; x++) begin
            win = (y >= g_y1) && (y < g_y1 + g_ir) && (x >= g_x1) && (x < g_x1 + g_ic);
            ed_q.push_back(win ? in_q[base + (y - g_y1) * g_ic + (x - g_x1)] : W'(PAD));
            eu_q.push_back((x == 0) && (y == 0));
            el_q.push_back(x == g_cols - 1);
         end
      end
   endtask

   task automatic exp_from_tbl(input int r);
      for (int i = 0; i < 16; i++) begin
         ed_q.push_back(W'(tbl[r].exp[i]));
         eu_q.push_back(i == 0);
         el_q.push_back((i % 4) == 3);
      end
   endtask

   task automatic compare_stream(input string tag);
      check({tag, " count"}, od_q.size(), ed_q.size());
      for (int i = 0; i < ed_q.size() && i < od_q.size(); i++)
         check($sformatf("%s px%0d {user,last,data}", tag, i),
               {ou_q[i], ol_q[i], od_q[i]}, {eu_q[i], el_q[i], ed_q[i]});
   endtask

   task automatic check_idle_after(input string tag);
      step(1'b0, 1'b1);
      check({tag, " busy_after"}, o_busy, 0);
      check({tag, " tvalid_after"}, o_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0].px = '{1, 2, 3, 4};        tbl[0].vmode = 0; tbl[0].rmode = 0;
      tbl[0].exp = '{7,7,7,7, 7,1,2,7, 7,3,4,7, 7,7,7,7};
      tbl[1].px = '{1, 2, 3, 4};        tbl[1].vmode = 1; tbl[1].rmode = 0;
      tbl[1].exp = '{7,7,7,7, 7,1,2,7, 7,3,4,7, 7,7,7,7};
      tbl[2].px = '{5, 6, 7, 8};        tbl[2].vmode = 0; tbl[2].rmode = 2;
      tbl[2].exp = '{7,7,7,7, 7,5,6,7, 7,7,8,7, 7,7,7,7};
      tbl[3].px = '{4095, 0, 2048, 7};  tbl[3].vmode = 2; tbl[3].rmode = 2;
      tbl[3].exp = '{7,7,7,7, 7,4095,0,7, 7,2048,7,7, 7,7,7,7};

      // Reset state of both instances
      select_dut(1'b0);
      do_reset();
      for (int s = 0; s < 2; s++) begin
         select_dut(s[0]);
         @(negedge clk); #1;
         check($sformatf("reset%0d tvalid", s), o_valid, 0);
         check($sformatf("reset%0d tdata", s), o_data, 0);
         check($sformatf("reset%0d tuser_tlast", s), {o_user, o_last}, 0);
         check($sformatf("reset%0d busy", s), o_busy, 0);
         check($sformatf("reset%0d in_ready", s), in_ready, 0);
      end

      // Vector table: one frame per record
      select_dut(1'b0);
      do_reset();
      for (int r = 0; r < 4; r++) begin
         clear_run();
         for (int i = 0; i < 4; i++) in_q.push_back(W'(tbl[r].px[i]));
         exp_from_tbl(r);
         run_stream(16, tbl[r].vmode, tbl[r].rmode);
         compare_stream($sformatf("tbl%0d", r));
         check($sformatf("tbl%0d consumed", r), idx, 4);
         if (tbl[r].vmode == 0 && tbl[r].rmode == 0 && oc_q.size() == 16) begin
            check($sformatf("tbl%0d last_cycle", r), oc_q[15], 18);
            check($sformatf("tbl%0d gapfree", r), oc_q[15] - oc_q[0], 15);
         end
         check_idle_after($sformatf("tbl%0d", r));
      end

      // Downstream stall while pixel 1 is presented
      clear_run();
      for (int i = 1; i <= 4; i++) in_q.push_back(W'(i));
      exp_from_tbl(0);
      while (od_q.size() < 5 && cyc < 100) step(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0);
         check($sformatf("stall%0d tvalid", k), o_valid, 1);
         check($sformatf("stall%0d tdata", k), o_data, 1);
         check($sformatf("stall%0d in_ready", k), in_ready, 0);
      end
      check("stall consumed", idx, 1);
      run_stream(16, 0, 0);
      compare_stream("stall");
      check_idle_after("stall");

      // Reset in the middle of a frame
      clear_run();
      for (int i = 1; i <= 4; i++) in_q.push_back(W'(i));
      while (od_q.size() < 6 && cyc < 100) step(1'b1, 1'b1);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk); #1;
      check("midreset tvalid", o_valid, 0);
      check("midreset busy", o_busy, 0);
      check("midreset tuser_tlast_tdata", {o_user, o_last, o_data}, 0);
      reset = 1'b0;
      clear_run();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1);
         check($sformatf("postreset%0d tvalid", k), o_valid, 0);
      end
      clear_run();
      for (int i = 1; i <= 4; i++) in_q.push_back(W'(i));
      exp_from_tbl(0);
      run_stream(16, 0, 0);
      compare_stream("after_reset");
      if (oc_q.size() == 16) check("after_reset last_cycle", oc_q[15], 18);
      check_idle_after("after_reset");

      // Two frames back to back
      clear_run();
      for (int i = 1; i <= 8; i++) in_q.push_back(W'(i));
      exp_from_tbl(0);
      exp_from_tbl(2);
      run_stream(32, 0, 0);
      compare_stream("b2b");
      check("b2b consumed", idx, 8);
      if (oc_q.size() == 32) begin
         check("b2b idle_gap", oc_q[16] - oc_q[15], 2);
         check("b2b frame2_gapfree", oc_q[31] - oc_q[16], 15);
      end
      check_idle_after("b2b");

      // Random frames against the reference model
      for (int f = 0; f < 6; f++) begin
         clear_run();
         for (int i = 0; i < 12; i++) in_q.push_back(W'($urandom));
         model_frame(0); model_frame(4); model_frame(8);
         run_stream(48, 2, 2);
         compare_stream($sformatf("rand%0d", f));
         check($sformatf("rand%0d consumed", f), idx, 12);
         check_idle_after($sformatf("rand%0d", f));
      end

      // Window in the bottom-right corner
      select_dut(1'b1);
      do_reset();
      clear_run();
      for (int i = 1; i <= 4; i++) in_q.push_back(W'(i));
      model_frame(0);
      run_stream(16, 0, 0);
      compare_stream("edge");
      if (od_q.size() == 16) begin
         check("edge out11", od_q[10], 1);
         check("edge out12", {ol_q[11], od_q[11]}, {1'b1, 12'd2});
         check("edge out15", od_q[14], 3);
         check("edge out16", {ol_q[15], od_q[15]}, {1'b1, 12'd4});
      end
      check_idle_after("edge");
      for (int f = 0; f < 2; f++) begin
         clear_run();
         for (int i = 0; i < 8; i++) in_q.push_back(W'($urandom));
         model_frame(0); model_frame(4);
         run_stream(32, 2, 2);
         compare_stream($sformatf("edge_rand%0d", f));
         check_idle_after($sformatf("edge_rand%0d", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crop_pad_embed.md
Name: crop_pad_embed

Overview:
- Re-embeds a cropped pixel stream (IN_ROWS x IN_COLS, raster order) into a larger OUT_ROWS x OUT_COLS frame.
- The window sits at row offset Y_1 and column offset X_1; every other position is filled with PAD_VALUE.
- This is the inverse of the team's crop stage. It lets cropped and filtered tiles be placed back into full-size frames before display/DMA.
- AXI-Stream-style valid/ready on both sides; output fully registered; adds start-of-frame (TUSER) and end-of-line (TLAST) markers.

Parameters:
- PIXEL_BIT_WIDTH, 12, pixel data width.
- IN_ROWS, 20, rows of incoming cropped frame.
- IN_COLS, 20, columns of incoming cropped frame.
- OUT_ROWS, 40, rows of emitted full frame.
- OUT_COLS, 40, columns of emitted full frame.
- Y_1, 10, output row of first window row.
- X_1, 10, output column of first window column.
- PAD_VALUE, 0, fill pixel value (PIXEL_BIT_WIDTH bits).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- pixel_in_TDATA  in  PIXEL_BIT_WIDTH  cropped pixel
- pixel_in_TVALID  in  1  input pixel valid
- pixel_in_TREADY  out  1  block accepts input pixel
- pixel_out_TDATA  out  PIXEL_BIT_WIDTH  full-frame pixel (registered)
- pixel_out_TVALID  out  1  output valid (registered)
- pixel_out_TREADY  in  1  downstream ready
- pixel_out_TUSER  out  1  high on output pixel (0,0) of each frame
- pixel_out_TLAST  out  1  high on last pixel of each output row (x == OUT_COLS-1)
- busy  out  1  frame in progress (state RUN or output register holding data)

Behaviour:
- Elaboration check: Y_1+IN_ROWS <= OUT_ROWS and X_1+IN_COLS <= OUT_COLS, else $error. Counter widths are $clog2(OUT_*)+1.
- Output coordinate counters x (column) and y (row) run over the output frame, raster order.
- in_win = (y >= Y_1) && (y < Y_1+IN_ROWS) && (x >= X_1) && (x < X_1+IN_COLS).
- load = (state==RUN) && (!pixel_out_TVALID || pixel_out_TREADY) && (in_win ? pixel_in_TVALID : 1).
- pixel_in_TREADY (combinational) = (state==RUN) && in_win && (!pixel_out_TVALID || pixel_out_TREADY). It is never high at pad positions, and never high in IDLE.
- States:
  - IDLE: wait for pixel_in_TVALID=1, then go to RUN with x=y=0. No output is generated in IDLE, so pad pixels are not free-running.
  - RUN: on each load, the output register takes data = in_win ? pixel_in_TDATA : PAD_VALUE, TUSER=(x==0&&y==0), TLAST=(x==OUT_COLS-1), TVALID=1. Then x increments. At x==OUT_COLS-1, x wraps to 0 and y increments. On the load at (OUT_COLS-1, OUT_ROWS-1), x and y go to 0 and state returns to IDLE.
- Output register holds (stable data/TUSER/TLAST, TVALID=1) while TVALID && !TREADY.
- TVALID clears when TREADY=1 and no new load occurs in the same cycle.
- Throughput: 1 pixel/cycle when downstream is always ready and input is valid at window positions. Pad positions emit back-to-back without consuming input.
- Latency: accepted input pixel appears on pixel_out one cycle later.
- A frame ends in IDLE. The next frame starts on the next pixel_in_TVALID, possibly the cycle after the final load. Back-to-back frames have exactly one IDLE cycle between them (no output load in that cycle).
- Input bubble at a window position: output stalls. The output register drains if ready, then TVALID drops. Counters hold.
- Reset (any time, incl. mid-frame): state=IDLE, x=y=0, pixel_out_TVALID=0, pixel_out_TDATA=0, TUSER=0, TLAST=0, busy=0. The partial frame is discarded; no pixel is emitted after reset until a new frame starts.
- Exactly IN_ROWS*IN_COLS inputs are consumed and OUT_ROWS*OUT_COLS outputs are emitted per frame.

Test Plan:
- Params IN 2x2, OUT 4x4, Y_1=1, X_1=1, PAD_VALUE=7. Inputs 1,2,3,4, both sides always valid/ready. Required output: 7,7,7,7, 7,1,2,7, 7,3,4,7, 7,7,7,7. TUSER only on the first pixel; TLAST on outputs 4,8,12,16; busy falls after the 16th pixel.
- Same params, pixel_out_TREADY held 0 for 3 cycles while the output shows pixel 1. Required: TDATA=1 stable, pixel_in_TREADY=0, no input consumed; stream resumes in order.
- pixel_in_TVALID toggles 1/0 each cycle in window. Required: pad pixels at 1/cycle; window pixels only on valid cycles; final stream identical to scenario 1.
- Two frames back-to-back (inputs 1-4 then 5-8). Required: 32 outputs, second-frame TUSER on output 17, exactly one IDLE cycle between frames, window shows 5,6,7,8.
- Reset asserted after output 6 of a frame. Required: next cycle TVALID=0, busy=0. A fresh frame of 1-4 then reproduces scenario 1 exactly.
- Edge window Y_1=2, X_1=2 (window at bottom-right corner). Required: output 11 = in[0], output 12 = in[1] with TLAST, output 15 = in[2], output 16 = in[3] with TLAST; return to IDLE.
